// File: rtl/instr_decode_ctrl.sv
// Multi-cycle decode/control stage: captures one instruction per handshake, decodes it and
// sequences register-file read, ALU execute and write-back. All outputs are registered.
module instr_decode_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InstrValid,
  input  logic [31:0]      Instr,
  output logic             InstrReady,
  output logic [4:0]       RR1,
  output logic [4:0]       RR2,
  output logic [4:0]       WR,
  output logic             WE,
  output logic [3:0]       Op,
  output logic [4:0]       ShiftCount,
  output logic [31:0]      Imm,
  output logic             AluSrc,
  output logic             Mux_Ctrl,
  output logic             IllegalInstr,
  output logic             Busy,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  state_e state_q, state_d;
  logic [31:0] instr_q;

  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign opc   = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];
  assign imm16 = instr_q[15:0];

  logic        dec_legal, dec_alusrc, dec_mux;
  logic [4:0]  dec_rr1, dec_rr2, dec_wr, dec_sh;
  logic [3:0]  dec_op;
  logic [31:0] dec_imm;

  always_comb begin
    dec_legal  = 1'b1;
    dec_rr1    = 5'd0;
    dec_rr2    = 5'd0;
    dec_wr     = 5'd0;
    dec_sh     = 5'd0;
    dec_op     = 4'b0000;
    dec_imm    = 32'd0;
    dec_alusrc = 1'b0;
    dec_mux    = 1'b1;
    if (opc == 6'h00) begin
      dec_wr  = rd;
      dec_rr1 = rs;
      dec_rr2 = rt;
      unique case (funct)
        6'h20: dec_op = 4'b0010;
        6'h22: dec_op = 4'b0110;
        6'h24: dec_op = 4'b0000;
        6'h25: dec_op = 4'b0001;
        6'h27: dec_op = 4'b1100;
        6'h2A: dec_op = 4'b0111;
        6'h00, 6'h02, 6'h03: begin
          // Shifts take their operand from rt and the amount from shamt.
          dec_rr1 = rt;
          dec_rr2 = 5'd0;
          dec_sh  = shamt;
          dec_op  = (funct == 6'h00) ? 4'b1110 : (funct == 6'h02) ? 4'b1101 : 4'b1111;
        end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_wr     = rt;
      dec_rr1    = rs;
      dec_alusrc = 1'b1;
      unique case (opc)
        6'h08: begin dec_op = 4'b0010; dec_imm = {{16{imm16[15]}}, imm16}; end
        6'h0A: begin dec_op = 4'b0111; dec_imm = {{16{imm16[15]}}, imm16}; end
        6'h0C: begin dec_op = 4'b0000; dec_imm = {16'h0, imm16}; end
        6'h0D: begin dec_op = 4'b0001; dec_imm = {16'h0, imm16}; end
        6'h0F: begin
          // LUI writes the shifted immediate straight through the write-data mux.
          dec_op     = 4'b0010;
          dec_imm    = {imm16, 16'h0};
          dec_mux    = 1'b0;
          dec_alusrc = 1'b0;
          dec_rr1    = 5'd0;
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  logic capture, load_dec, we_d, ill_d, retire;

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_dec = 1'b0;
    we_d     = 1'b0;
    ill_d    = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (InstrValid && InstrReady) begin
          capture = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_legal) begin
          load_dec = 1'b1;
          state_d  = StExec;
        end else begin
          ill_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StExec: begin
        we_d    = (WR != 5'd0);
        state_d = StWb;
      end
      StWb: begin
        retire = 1'b1;
        if (InstrValid && InstrReady) begin
          capture = 1'b1;
          state_d = StDecode;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= StIdle;
      instr_q      <= 32'd0;
      InstrReady   <= 1'b1;
      RR1          <= 5'd0;
      RR2          <= 5'd0;
      WR           <= 5'd0;
      WE           <= 1'b0;
      Op           <= 4'd0;
      ShiftCount   <= 5'd0;
      Imm          <= 32'd0;
      AluSrc       <= 1'b0;
      Mux_Ctrl     <= 1'b0;
      IllegalInstr <= 1'b0;
      Busy         <= 1'b0;
      RetireCount  <= '0;
    end else begin
      state_q      <= state_d;
      InstrReady   <= (state_d == StIdle) || (state_d == StWb);
      Busy         <= (state_d != StIdle);
      WE           <= we_d;
      IllegalInstr <= ill_d;
      if (capture) instr_q <= Instr;
      if (load_dec) begin
        RR1        <= dec_rr1;
        RR2        <= dec_rr2;
        WR         <= dec_wr;
        Op         <= dec_op;
        ShiftCount <= dec_sh;
        Imm        <= dec_imm;
        AluSrc     <= dec_alusrc;
        Mux_Ctrl   <= dec_mux;
      end
      if (retire) RetireCount <= RetireCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed self-checking bench for instr_decode_ctrl; samples outputs on the falling edge.
module tb_instr_decode_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InstrValid;
  logic [31:0] Instr;
  logic        InstrReady, WE, AluSrc, Mux_Ctrl, IllegalInstr, Busy;
  logic [4:0]  RR1, RR2, WR, ShiftCount;
  logic [3:0]  Op;
  logic [31:0] Imm;
  logic [15:0] RetireCount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  instr_decode_ctrl #(.CNT_W(16)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .InstrReady   (InstrReady),
    .RR1          (RR1),
    .RR2          (RR2),
    .WR           (WR),
    .WE           (WE),
    .Op           (Op),
    .ShiftCount   (ShiftCount),
    .Imm          (Imm),
    .AluSrc       (AluSrc),
    .Mux_Ctrl     (Mux_Ctrl),
    .IllegalInstr (IllegalInstr),
    .Busy         (Busy),
    .RetireCount  (RetireCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check_dec(input string tag, input logic [4:0] rr1, input logic [4:0] rr2,
                           input logic [4:0] wr, input logic [3:0] op, input logic [4:0] sh,
                           input logic [31:0] imm, input logic alusrc, input logic mux);
    check({tag, ".RR1"}, 32'(RR1), 32'(rr1));
    check({tag, ".RR2"}, 32'(RR2), 32'(rr2));
    check({tag, ".WR"}, 32'(WR), 32'(wr));
    check({tag, ".Op"}, 32'(Op), 32'(op));
    check({tag, ".ShiftCount"}, 32'(ShiftCount), 32'(sh));
    check({tag, ".Imm"}, Imm, imm);
    check({tag, ".AluSrc"}, 32'(AluSrc), 32'(alusrc));
    check({tag, ".Mux_Ctrl"}, 32'(Mux_Ctrl), 32'(mux));
  endtask

  // Offers one instruction from IDLE and walks it through DECODE/EXEC/WB.
  task automatic run_one(input string tag, input logic [31:0] word, input logic exp_we,
                         input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] wr,
                         input logic [3:0] op, input logic [4:0] sh, input logic [31:0] imm,
                         input logic alusrc, input logic mux, input int exp_retire);
    Instr = word;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
    check({tag, ".dec_busy"}, 32'(Busy), 32'd1);
    check({tag, ".dec_ready"}, 32'(InstrReady), 32'd0);
    step();
    check({tag, ".exec_we"}, 32'(WE), 32'd0);
    check_dec(tag, rr1, rr2, wr, op, sh, imm, alusrc, mux);
    step();
    check({tag, ".wb_we"}, 32'(WE), 32'(exp_we));
    check({tag, ".wb_ready"}, 32'(InstrReady), 32'd1);
    step();
    check({tag, ".after_we"}, 32'(WE), 32'd0);
    check({tag, ".retire"}, 32'(RetireCount), 32'(exp_retire));
    check({tag, ".idle_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    Rst = 1'b1;
    InstrValid = 1'b0;
    Instr = 32'd0;
    #3;
    check("rst.ready", 32'(InstrReady), 32'd1);
    check("rst.we", 32'(WE), 32'd0);
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.retire", 32'(RetireCount), 32'd0);
    check("rst.imm", Imm, 32'd0);
    check("rst.mux", 32'(Mux_Ctrl), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // add $5,$3,$0
    run_one("add", 32'h0060_2820, 1'b1, 5'd3, 5'd0, 5'd5, 4'b0010, 5'd0, 32'd0, 1'b0, 1'b1, 1);
    // sra $7,$2,2
    run_one("sra", 32'h0002_3883, 1'b1, 5'd2, 5'd0, 5'd7, 4'b1111, 5'd2, 32'd0, 1'b0, 1'b1, 2);

    // ori $9,$0,0xFF followed by addi $4,$1,-3 offered during WB
    Instr = 32'h3409_00FF;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
    step();
    check_dec("ori", 5'd0, 5'd0, 5'd9, 4'b0001, 5'd0, 32'h0000_00FF, 1'b1, 1'b1);
    step();
    check("ori.wb_we", 32'(WE), 32'd1);
    check("ori.wb_ready", 32'(InstrReady), 32'd1);
    Instr = 32'h2024_FFFD;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
    check("b2b.we_low", 32'(WE), 32'd0);
    check("b2b.busy", 32'(Busy), 32'd1);
    check("b2b.ready", 32'(InstrReady), 32'd0);
    check("b2b.retire", 32'(RetireCount), 32'd3);
    step();
    check("b2b.exec_we", 32'(WE), 32'd0);
    check_dec("addi", 5'd1, 5'd0, 5'd4, 4'b0010, 5'd0, 32'hFFFF_FFFD, 1'b1, 1'b1);
    step();
    check("addi.wb_we", 32'(WE), 32'd1);
    step();
    check("addi.after_we", 32'(WE), 32'd0);
    check("addi.retire", 32'(RetireCount), 32'd4);

    // lui $6,0x1234
    run_one("lui", 32'h3C06_1234, 1'b1, 5'd0, 5'd0, 5'd6, 4'b0010, 5'd0, 32'h1234_0000,
            1'b0, 1'b0, 5);

    // Illegal opcode
    Instr = 32'hFC00_0000;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
    check("ill.dec_pulse", 32'(IllegalInstr), 32'd0);
    step();
    check("ill.pulse", 32'(IllegalInstr), 32'd1);
    check("ill.we", 32'(WE), 32'd0);
    check("ill.busy", 32'(Busy), 32'd0);
    check("ill.ready", 32'(InstrReady), 32'd1);
    step();
    check("ill.pulse_end", 32'(IllegalInstr), 32'd0);
    check("ill.we2", 32'(WE), 32'd0);
    check("ill.retire", 32'(RetireCount), 32'd5);

    // add $0,$1,$2: retires without writing
    run_one("wr0", 32'h0022_0020, 1'b0, 5'd1, 5'd2, 5'd0, 4'b0010, 5'd0, 32'd0, 1'b0, 1'b1, 6);

    // Reset asserted during EXEC
    Instr = 32'h0060_2820;
    InstrValid = 1'b1;
    step();
    InstrValid = 1'b0;
    step();
    check("pre_rst.rr1", 32'(RR1), 32'd3);
    Rst = 1'b1;
    #1;
    check("mid_rst.rr1", 32'(RR1), 32'd0);
    check("mid_rst.wr", 32'(WR), 32'd0);
    check("mid_rst.we", 32'(WE), 32'd0);
    check("mid_rst.ready", 32'(InstrReady), 32'd1);
    check("mid_rst.busy", 32'(Busy), 32'd0);
    check("mid_rst.retire", 32'(RetireCount), 32'd0);
    check("mid_rst.mux", 32'(Mux_Ctrl), 32'd0);
    #2;
    Rst = 1'b0;
    @(negedge Clk);
    run_one("post_rst", 32'h0002_3883, 1'b1, 5'd2, 5'd0, 5'd7, 4'b1111, 5'd2, 32'd0,
            1'b0, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Multi-cycle decode/control stage directly upstream of the register file, ALU and 32-bit write-data mux.
- Accepts one 32-bit MIPS-style instruction per valid/ready handshake and decodes it.
- Sequences the read, execute and write-back steps by driving register addresses, ALU op, shift count, immediate, mux selects and the register-file write enable.
- Flags illegal encodings and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- InstrValid  in  1  instruction offered.
- Instr  in  32  instruction word.
- InstrReady  out  1  block can accept an instruction this cycle.
- RR1  out  5  register-file read address 1 (ALU A).
- RR2  out  5  register-file read address 2 (ALU B).
- WR  out  5  register-file write address.
- WE  out  1  register-file write enable.
- Op  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1110 SLL, 1101 SRL, 1111 SRA.
- ShiftCount  out  5  ALU shift amount.
- Imm  out  32  extended immediate; feeds write-data mux input 0 and ALU-B immediate path.
- AluSrc  out  1  0 selects register B, 1 selects Imm as ALU B.
- Mux_Ctrl  out  1  write-data select: 0 selects Imm, 1 selects ALU result.
- IllegalInstr  out  1  one-cycle pulse on an undecodable instruction.
- Busy  out  1  high in every state except IDLE.
- RetireCount  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs are 0 except InstrReady=1.
  - The captured instruction is discarded.
  - WE drops without waiting for a clock edge.
- All outputs are registered; none are combinational from Instr.
- States: IDLE, DECODE, EXEC, WB.
- IDLE:
  - InstrReady=1.
  - On InstrValid&InstrReady, capture Instr and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - Decode the captured word.
  - Register RR1, RR2, WR, Op, ShiftCount, Imm, AluSrc, Mux_Ctrl.
  - Illegal encoding: pulse IllegalInstr for 1 cycle, go to IDLE, no WE, RetireCount unchanged.
  - Legal encoding: go to EXEC.
- EXEC:
  - Outputs held stable.
  - WE=0.
  - Go to WB.
- WB:
  - WE=1 for exactly this one cycle, unless WR==0 (register 0 is never written; WE stays 0).
  - RetireCount increments on leaving WB, in both cases.
  - InstrReady=1 in WB. A handshake in WB captures the next instruction and goes straight to DECODE; otherwise go to IDLE.
- Latency: handshake at edge N → WE high from edge N+2 to edge N+3. Back-to-back throughput is one instruction per 3 cycles.
- Field slices:
  - rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], opc=[31:26], imm=[15:0].
- R-type (opc=0):
  - Common outputs: WR=rd, AluSrc=0, Mux_Ctrl=1.
  - funct 20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOR, 2A SLT (hex): RR1=rs, RR2=rt, ShiftCount=0.
  - funct 00 SLL, 02 SRL, 03 SRA: RR1=rt, RR2=0, ShiftCount=shamt.
  - Any other funct is illegal.
- I-type:
  - Common outputs: WR=rt, RR1=rs, RR2=0, AluSrc=1, Mux_Ctrl=1.
  - opc 08 ADDI: Op=0010, Imm sign-extended.
  - opc 0A SLTI: Op=0111, Imm sign-extended.
  - opc 0C ANDI: Op=0000, Imm zero-extended.
  - opc 0D ORI: Op=0001, Imm zero-extended.
  - opc 0F LUI: Imm={imm,16'h0}, Mux_Ctrl=0, AluSrc=0, Op=0010, RR1=0.
  - Any other opcode is illegal.
- RetireCount wraps from all-ones to 0.
- InstrValid while InstrReady=0 is ignored; the source must hold it.

Test Plan:
- Single R-type: reset, then offer 0x00602820 (add $5,$3,$0) → RR1=3, RR2=0, WR=5, Op=0010, Mux_Ctrl=1, AluSrc=0; WE=1 exactly 2 cycles after the handshake, for 1 cycle; RetireCount=1.
- Shift: 0x00023883 (sra $7,$2,2) → RR1=2, ShiftCount=2, Op=1111, WR=7, WE pulse.
- Back-to-back immediates: 0x2024FFFD (addi $4,$1,-3) held valid in WB of the previous instruction → accepted in WB; Imm=0xFFFFFFFD, AluSrc=1, WR=4; 3-cycle spacing between WE pulses.
- LUI: 0x3C061234 → Imm=0x12340000, Mux_Ctrl=0, WR=6, WE pulse.
- Illegal and write-to-zero:
  - 0xFC000000 → IllegalInstr 1-cycle pulse, no WE, RetireCount unchanged.
  - 0x00220020 (add $0,$1,$2) → WE stays 0, RetireCount increments.
- Reset mid-operation: assert Rst during EXEC → WE and all outputs 0 immediately, InstrReady=1, RetireCount=0; the next instruction decodes normally.
